// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - DCache request/response bus between load/store unit and DCache
interface load_store_unit_if;
    logic        read_request;
    logic        write_request;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        response;
    logic [31:0] read_data;

    modport master (
        output read_request,
        output write_request,
        output addr,
        output write_data,
        input  response,
        input  read_data
    );

    modport slave (
        input  read_request,
        input  write_request,
        input  addr,
        input  write_data,
        output response,
        output read_data
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store stage issuing word-aligned DCache accesses
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [2:0]         funct3,
    input  logic [31:0]        address,
    input  logic [31:0]        store_data,
    output logic [31:0]        load_data,
    output logic               stall,
    output logic               misaligned,
    output logic               access_fault,
    load_store_unit_if.master  dc
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        READ      = 3'd1,
        WRITE     = 3'd2,
        RMW_READ  = 3'd3,
        RMW_WRITE = 3'd4,
        DONE      = 3'd5
    } state_t;

    state_t      state_q;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;
    logic [31:0] store_data_q;
    logic [31:0] addr_q;
    logic [31:0] write_data_q;
    logic [31:0] load_data_q;
    logic        read_request_q;
    logic        write_request_q;
    logic        misaligned_q;
    logic        access_fault_q;
    logic [31:0] tmo_cnt_q;

    logic        op_valid;
    logic        misaligned_cond;
    logic        timeout_hit;
    logic [4:0]  lane_shift;
    logic [31:0] lane_data;
    logic [31:0] lane_mask;
    logic [31:0] load_data_d;
    logic [31:0] write_data_d;

    assign op_valid    = mem_read | mem_write;
    assign stall       = op_valid & (state_q != DONE) & ~misaligned_cond;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt_q == TIMEOUT_CYCLES - 1);

    // Only a freshly presented op in IDLE is checked; a store widens the illegal set to BU/HU
    always_comb begin
        misaligned_cond = 1'b0;
        if (state_q == IDLE && op_valid) begin
            misaligned_cond = (funct3 == 3'b011) || (funct3[2] && funct3[1])
                           || (mem_write && funct3[2])
                           || (funct3[1:0] == 2'b01 && address[0])
                           || (funct3[1:0] == 2'b10 && address[1:0] != 2'b00);
        end
    end

    // Halfword offsets are always even here, so one byte-granular shift serves both widths
    always_comb begin
        lane_shift   = {offset_q, 3'b000};
        lane_data    = dc.read_data >> lane_shift;
        lane_mask    = (funct3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << lane_shift;
        write_data_d = (dc.read_data & ~lane_mask) | ((store_data_q << lane_shift) & lane_mask);
        case (funct3_q)
            3'b000:  load_data_d = {{24{lane_data[7]}}, lane_data[7:0]};
            3'b100:  load_data_d = {24'd0, lane_data[7:0]};
            3'b001:  load_data_d = {{16{lane_data[15]}}, lane_data[15:0]};
            3'b101:  load_data_d = {16'd0, lane_data[15:0]};
            default: load_data_d = dc.read_data;
        endcase
    end

    // Access sequencer: one outstanding request, registered DCache and status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            funct3_q        <= 3'd0;
            offset_q        <= 2'd0;
            store_data_q    <= 32'd0;
            addr_q          <= 32'd0;
            write_data_q    <= 32'd0;
            load_data_q     <= 32'd0;
            read_request_q  <= 1'b0;
            write_request_q <= 1'b0;
            misaligned_q    <= 1'b0;
            access_fault_q  <= 1'b0;
            tmo_cnt_q       <= 32'd0;
        end else begin
            misaligned_q   <= misaligned_cond;
            access_fault_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (op_valid && !misaligned_cond) begin
                        funct3_q     <= funct3;
                        offset_q     <= address[1:0];
                        store_data_q <= store_data;
                        addr_q       <= {address[31:2], 2'b00};
                        tmo_cnt_q    <= 32'd0;
                        if (!mem_write) begin
                            read_request_q <= 1'b1;
                            state_q        <= READ;
                        end else if (funct3 == 3'b010) begin
                            write_data_q    <= store_data;
                            write_request_q <= 1'b1;
                            state_q         <= WRITE;
                        end else begin
                            read_request_q <= 1'b1;
                            state_q        <= RMW_READ;
                        end
                    end
                end
                READ, WRITE, RMW_READ, RMW_WRITE: begin
                    if (dc.response) begin
                        read_request_q  <= 1'b0;
                        write_request_q <= 1'b0;
                        tmo_cnt_q       <= 32'd0;
                        if (state_q == READ) begin
                            load_data_q <= load_data_d;
                            state_q     <= DONE;
                        end else if (state_q == RMW_READ) begin
                            write_data_q    <= write_data_d;
                            write_request_q <= 1'b1;
                            state_q         <= RMW_WRITE;
                        end else begin
                            state_q <= DONE;
                        end
                    end else if (timeout_hit) begin
                        read_request_q  <= 1'b0;
                        write_request_q <= 1'b0;
                        access_fault_q  <= 1'b1;
                        tmo_cnt_q       <= 32'd0;
                        state_q         <= DONE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 32'd1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign load_data        = load_data_q;
    assign misaligned       = misaligned_q;
    assign access_fault     = access_fault_q;
    assign dc.read_request  = read_request_q;
    assign dc.write_request = write_request_q;
    assign dc.addr          = addr_q;
    assign dc.write_data    = write_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit
module tb_load_store_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, rst2;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] address, store_data, load_data;
    logic        stall, misaligned, access_fault;
    logic        mem_read2, mem_write2;
    logic [2:0]  funct3_2;
    logic [31:0] address2, store_data2, load_data2;
    logic        stall2, misaligned2, access_fault2;

    load_store_unit_if ifc();
    load_store_unit_if ifc2();

    load_store_unit dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .address(address), .store_data(store_data),
        .load_data(load_data), .stall(stall), .misaligned(misaligned),
        .access_fault(access_fault), .dc(ifc.master)
    );

    load_store_unit #(.TIMEOUT_CYCLES(8)) dut2 (
        .clk(clk), .reset(rst2), .mem_read(mem_read2), .mem_write(mem_write2),
        .funct3(funct3_2), .address(address2), .store_data(store_data2),
        .load_data(load_data2), .stall(stall2), .misaligned(misaligned2),
        .access_fault(access_fault2), .dc(ifc2.master)
    );

    int total = 0;
    int bad   = 0;
    logic [7:0]  ref_bytes [64];
    logic [31:0] cache_mem [16];
    logic [31:0] exp_ld;
    int          n_rd, n_wr;
    logic [31:0] rd_addr, wr_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int w);
        return {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]};
    endfunction

    task automatic preload(input int w, input logic [31:0] v);
        cache_mem[w] = v;
        for (int i = 0; i < 4; i++) ref_bytes[4*w+i] = 8'(v >> (8*i));
    endtask

    // DCache emulator: random latency, one-cycle response per request
    initial begin : responder
        int dly;
        ifc.response  = 1'b0;
        ifc.read_data = 32'hDEAD_BEEF;
        dly = $urandom_range(0, 3);
        forever begin
            @(negedge clk);
            if (ifc.response) begin
                ifc.response  = 1'b0;
                ifc.read_data = $urandom;
                dly = $urandom_range(0, 3);
            end else if (ifc.read_request || ifc.write_request) begin
                if (dly == 0) begin
                    ifc.response = 1'b1;
                    if (ifc.write_request) begin
                        cache_mem[ifc.addr[5:2]] = ifc.write_data;
                        n_wr++;
                        wr_addr = ifc.addr;
                    end else begin
                        ifc.read_data = cache_mem[ifc.addr[5:2]];
                        n_rd++;
                        rd_addr = ifc.addr;
                    end
                end else begin
                    dly--;
                end
            end
        end
    end

    task automatic do_op(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, output logic [31:0] got);
        int sz, cycles;
        bit legal, mis;
        logic [31:0] val;
        sz    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = wr ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
        mis   = !legal || (a % sz != 0);
        if (!mis) begin
            if (wr) begin
                for (int i = 0; i < sz; i++) ref_bytes[(a + i) % 64] = 8'(sd >> (8*i));
            end else begin
                val = 32'd0;
                for (int i = 0; i < sz; i++) val = val | (32'(ref_bytes[(a + i) % 64]) << (8*i));
                if (!f3[2] && sz < 4 && val[8*sz-1]) val = val - (32'd1 << (8*sz));
                exp_ld = val;
            end
        end
        @(posedge clk); #1;
        n_rd = 0; n_wr = 0;
        mem_write = wr; mem_read = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        funct3 = f3; address = a; store_data = sd;
        cycles = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stall) break;
            cycles++;
        end
        check("op_done", stall, 0);
        got = load_data;
        check("load_data", load_data, exp_ld);
        check("no_fault", access_fault, 0);
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        check("misaligned", misaligned, mis);
        if (mis) begin
            check("mis_stall", cycles, 0);
            check("mis_reads", n_rd, 0);
            check("mis_writes", n_wr, 0);
        end else begin
            check("reads", n_rd, (wr && sz == 4) ? 0 : 1);
            check("writes", n_wr, wr ? 1 : 0);
            if (n_rd > 0) check("rd_addr", rd_addr, a & ~32'd3);
            if (wr) begin
                check("wr_addr", wr_addr, a & ~32'd3);
                check("wr_word", cache_mem[a[5:2]], ref_word(int'(a[5:2])));
            end
        end
    endtask

    task automatic run2(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                        output int rh, output int wh, output int fc);
        @(posedge clk); #1;
        mem_read2 = !wr; mem_write2 = wr; funct3_2 = f3; address2 = a; store_data2 = 32'h55;
        rh = 0; wh = 0; fc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            rh += int'(ifc2.read_request);
            wh += int'(ifc2.write_request);
            fc += int'(access_fault2);
            if (!stall2) break;
        end
        check("t_done", stall2, 0);
        @(posedge clk); #1;
        mem_read2 = 1'b0; mem_write2 = 1'b0;
        @(negedge clk);
        check("t_fault_pulse", access_fault2, 0);
    endtask

    initial begin : main
        logic [31:0] got;
        int rh, wh, fc;
        bit wr;
        logic [2:0] f3;
        logic [31:0] a;
        logic [2:0] legal_f3 [5];
        legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd2;
        legal_f3[3] = 3'd4; legal_f3[4] = 3'd5;
        reset = 1'b1; rst2 = 1'b1;
        mem_read = 0; mem_write = 0; funct3 = 0; address = 0; store_data = 0;
        mem_read2 = 0; mem_write2 = 0; funct3_2 = 0; address2 = 0; store_data2 = 0;
        ifc2.response = 1'b0; ifc2.read_data = 32'hA5A5_5A5A;
        exp_ld = 32'd0;
        for (int w = 0; w < 16; w++) preload(w, $urandom);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0; rst2 = 1'b0;
        @(negedge clk);
        check("rst_load_data", load_data, 0);
        check("rst_rreq", ifc.read_request, 0);
        check("rst_wreq", ifc.write_request, 0);
        check("rst_addr", ifc.addr, 0);
        check("rst_wdata", ifc.write_data, 0);
        check("rst_stall", stall, 0);
        check("rst_flags", {misaligned, access_fault}, 0);

        preload(2, 32'h1122_3344);
        do_op(0, 3'b010, 32'h8, 0, got);            check("lw_8", got, 32'h1122_3344);
        do_op(1, 3'b010, 32'h14, 32'h6a6a_6a6a, got);
        do_op(0, 3'b010, 32'h14, 0, got);           check("lw_14", got, 32'h6a6a_6a6a);
        preload(1, 32'h736F_6669);
        do_op(1, 3'b000, 32'h5, 32'h0000_0069, got); check("sb_word", cache_mem[1], 32'h736F_6969);
        do_op(0, 3'b000, 32'h7, 0, got);            check("lb_7", got, 32'h0000_0073);
        do_op(0, 3'b001, 32'h6, 0, got);            check("lh_6", got, 32'h0000_736F);
        preload(0, 32'h80FF_FFFF);
        do_op(0, 3'b000, 32'h3, 0, got);            check("lb_3", got, 32'hFFFF_FF80);
        do_op(0, 3'b100, 32'h3, 0, got);            check("lbu_3", got, 32'h0000_0080);
        preload(3, 32'h8001_ABCD);
        do_op(0, 3'b101, 32'hE, 0, got);            check("lhu_e", got, 32'h0000_8001);
        do_op(0, 3'b010, 32'h6, 0, got);
        do_op(1, 3'b001, 32'h1, 32'h1234, got);
        do_op(0, 3'b011, 32'h0, 0, got);
        do_op(1, 3'b100, 32'h4, 32'h77, got);

        for (int n = 0; n < 300; n++) begin
            wr = 1'($urandom_range(0, 1));
            f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom) : legal_f3[$urandom_range(0, 4)];
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~32'd3;
            do_op(wr, f3, a, $urandom, got);
        end
        for (int w = 0; w < 16; w++) check("final_mem", cache_mem[w], ref_word(w));

        run2(0, 3'b010, 32'h8, rh, wh, fc);
        check("t_lw_req_cycles", rh, 8);
        check("t_lw_fault", fc, 1);
        run2(1, 3'b000, 32'h5, rh, wh, fc);
        check("t_sb_req_cycles", rh, 8);
        check("t_sb_no_write", wh, 0);
        check("t_sb_fault", fc, 1);
        @(posedge clk); #1;
        mem_write2 = 1'b1; funct3_2 = 3'b001; address2 = 32'h22; store_data2 = 32'hBEEF;
        repeat (3) @(negedge clk);
        check("t_rmw_active", ifc2.read_request, 1);
        rst2 = 1'b1;
        #1;
        check("t_rst_rreq", ifc2.read_request, 0);
        check("t_rst_wreq", ifc2.write_request, 0);
        mem_write2 = 1'b0;
        @(posedge clk); #1 rst2 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Pipeline memory-access stage that sits directly upstream of DCache and converts RV32I load/store micro-ops into word-aligned DCache requests. It extracts and sign/zero-extends byte and halfword loads. DCache has no byte enables, so byte and halfword stores are done as read-modify-write. It stalls the pipeline until the access completes and flags misaligned or illegal accesses without touching the cache.

Parameters:
TIMEOUT_CYCLES, 1024, number of cycles a cache request may stay outstanding without response before abort; 0 disables the timeout.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
mem_read  input  1  pipeline requests a load this cycle (level, held while stall=1)
mem_write  input  1  pipeline requests a store (level, held while stall=1); wins if both high
funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
address  input  32  byte address from ALU
store_data  input  32  rs2 value; low byte/half used for SB/SH
load_data  output  32  extended load result, valid in DONE cycle, held until next DONE
stall  output  1  freeze upstream pipeline
misaligned  output  1  one-cycle pulse: misaligned or illegal funct3, no cache access
access_fault  output  1  one-cycle pulse: cache timeout
read_request  output  1  to DCache
write_request  output  1  to DCache
addr  output  32  to DCache, always {address[31:2],2'b00}
write_data  output  32  to DCache
response  input  1  from DCache, access complete (level)
read_data  input  32  from DCache, valid while response=1

Behaviour:
- Reset (async): state IDLE; read_request, write_request, misaligned, access_fault = 0; load_data, write_data, addr = 0; timeout counter 0. Reset mid-access drops requests immediately; the access is lost.
- States: IDLE, READ, WRITE, RMW_READ, RMW_WRITE, DONE.
- stall = (mem_read|mem_write) & ~(state==DONE) & ~misaligned_cond, combinational. It is high in the same cycle a request appears.
- Check in IDLE: misaligned_cond = H/HU/SH with address[0]=1; W with address[1:0]!=0; funct3 in {011,110,111}; stores with funct3 100/101. If true: misaligned pulses, stall=0, no request, stay IDLE, load_data unchanged.
- IDLE -> READ for a load, and for a store with funct3=010 -> WRITE with write_data=store_data. Any other store -> RMW_READ. On entry, latch funct3, address[1:0], store_data and addr, and assert the request at the next edge.
- A request stays high until the cycle response=1 is sampled and drops at the following edge. One request is outstanding at a time.
- READ on response: load_data = extract(read_data), -> DONE.
- extract: byte lane address[1:0]*8, half lane address[1]*16. B/H sign-extend; BU/HU zero-extend; W pass-through.
- RMW_READ on response: merge store_data[7:0] or [15:0] into read_data at the lane, keep other bytes, -> RMW_WRITE with write_request=1 and write_data=merged.
- WRITE/RMW_WRITE on response: -> DONE. load_data is unchanged on stores.
- DONE: exactly one cycle with stall=0 and both requests low; -> IDLE. The pipeline advances at this edge. A new op sampled in IDLE on the next cycle adds a one-cycle bubble.
- Timeout: counter counts cycles with a request high and no response. At TIMEOUT_CYCLES, drop the request, pulse access_fault, -> DONE. An RMW aborted during the read does not write.
- If response is already high in the same cycle a request rises, it is accepted as completion.

Test Plan:
- LW at 0x8, cache returns 0x11223344 -> one read_request at addr 0x8; load_data=0x11223344; stall low exactly one cycle (DONE).
- SW 0x6a6a6a6a at 0x14 -> single write_request, addr 0x14, write_data 0x6a6a6a6a, no read; then LW 0x14 returns 0x6a6a6a6a.
- SB 0x69 at 0x5, word 0x736F6669 -> read addr 0x4, then write 0x736F6969; LB 0x7 -> 0x00000073; LH 0x6 -> 0x0000736F.
- LB at 0x3 with word 0x80FFFFFF -> 0xFFFFFF80; LBU -> 0x00000080; LHU at 0x2 with 0x8001xxxx -> 0x00008001.
- LW at 0x6, SH at 0x1, funct3=011 -> misaligned pulses, no cache request, stall=0.
- TIMEOUT_CYCLES=8 with response tied low -> request high 8 cycles, access_fault pulse, DONE; async reset asserted mid-RMW clears requests the same cycle.
